countdown_timer: RTL and testbench

COUNTDOWN_TIMER -- requirements
Module: countdown_timer

---
 rtl/countdown_timer.sv | 120 ++++++++++++
 tb/tb_countdown_timer.sv | 243 ++++++++++++++++++++++++
 2 files changed

// File: rtl/countdown_timer.sv
// BCD mm:ss countdown timer with load/start/pause control.
// Counts down on tick while running; pulses done at 00:00.
module countdown_timer (
  input  logic       clk,
  input  logic       rst,
  input  logic       tick,
  input  logic       load,
  input  logic [7:0] load_min,
  input  logic [7:0] load_sec,
  input  logic       start,
  input  logic       pause,
  output logic [7:0] min,
  output logic [7:0] sec,
  output logic       running,
  output logic       done,
  output logic       err
);

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    PAUSE,
    EXPIRED
  } state_t;

  state_t     state;
  logic       ld_ok;
  logic       zero;
  logic       last;
  logic [7:0] dmin;
  logic [7:0] dsec;

  assign ld_ok = (load_min[7:4] <= 4'd9) &&
                 (load_min[3:0] <= 4'd9) &&
                 (load_sec[7:4] <= 4'd5) &&
                 (load_sec[3:0] <= 4'd9);

  assign zero = (min == 8'h00) && (sec == 8'h00);
  assign last = (min == 8'h00) && (sec == 8'h01);

  // BCD borrow chain, one second down
  always_comb begin
    dmin = min;
    dsec = sec;
    if (sec[3:0] != 4'd0) begin
      dsec[3:0] = sec[3:0] - 4'd1;
    end else begin
      dsec[3:0] = 4'd9;
      if (sec[7:4] != 4'd0) begin
        dsec[7:4] = sec[7:4] - 4'd1;
      end else begin
        dsec[7:4] = 4'd5;
        if (min[3:0] != 4'd0) begin
          dmin[3:0] = min[3:0] - 4'd1;
        end else begin
          dmin[3:0] = 4'd9;
          dmin[7:4] = min[7:4] - 4'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      min     <= 8'h00;
      sec     <= 8'h00;
      running <= 1'b0;
      done    <= 1'b0;
      err     <= 1'b0;
    end else begin
      done <= 1'b0;
      err  <= 1'b0;
      if (load && state != RUN) begin
        if (ld_ok) begin
          min     <= load_min;
          sec     <= load_sec;
          state   <= IDLE;
          running <= 1'b0;
        end else begin
          err <= 1'b1;
        end
      end else begin
        unique case (state)
          RUN: begin
            // expiry outranks a coincident pause
            if (tick && last) begin
              min     <= 8'h00;
              sec     <= 8'h00;
              state   <= EXPIRED;
              running <= 1'b0;
              done    <= 1'b1;
            end else begin
              if (tick && !zero) begin
                min <= dmin;
                sec <= dsec;
              end
              if (pause) begin
                state   <= PAUSE;
                running <= 1'b0;
              end
            end
          end
          IDLE, PAUSE: begin
            if (start && !zero) begin
              state   <= RUN;
              running <= 1'b1;
            end
          end
          EXPIRED: begin
            min <= 8'h00;
            sec <= 8'h00;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_countdown_timer.sv
// Bench for countdown_timer: directed scenarios then random
// traffic against a seconds-count reference model.
module tb_countdown_timer;

  logic       clk = 1'b0;
  logic       rst;
  logic       tick;
  logic       load;
  logic [7:0] load_min;
  logic [7:0] load_sec;
  logic       start;
  logic       pause;
  logic [7:0] min;
  logic [7:0] sec;
  logic       running;
  logic       done;
  logic       err;

  int passed = 0;
  int total  = 0;
  int fails  = 0;

  // reference: total seconds and a mode number
  // mode 0 idle, 1 run, 2 pause, 3 expired
  int m_secs = 0;
  int m_mode = 0;
  bit m_done = 0;
  bit m_err  = 0;

  always #5 clk = ~clk;

  countdown_timer dut (
    .clk     (clk),
    .rst     (rst),
    .tick    (tick),
    .load    (load),
    .load_min(load_min),
    .load_sec(load_sec),
    .start   (start),
    .pause   (pause),
    .min     (min),
    .sec     (sec),
    .running (running),
    .done    (done),
    .err     (err)
  );

  function automatic logic [7:0] bcd(input int v);
    logic [3:0] t;
    logic [3:0] u;
    t = 4'(v / 10);
    u = 4'(v % 10);
    return {t, u};
  endfunction

  function automatic int dec(input logic [7:0] b);
    return int'(b[7:4]) * 10 + int'(b[3:0]);
  endfunction

  task automatic chk(input string tag,
                     input logic [7:0] obs,
                     input logic [7:0] exp);
    total++;
    assert (obs === exp) passed++;
    else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic model(input bit r, tk, ld,
                       input logic [7:0] lm, ls,
                       input bit st, ps);
    bit ok;
    ok = (lm[7:4] <= 9) && (lm[3:0] <= 9) &&
         (ls[7:4] <= 5) && (ls[3:0] <= 9);
    m_done = 0;
    m_err  = 0;
    if (r) begin
      m_secs = 0;
      m_mode = 0;
    end else if (ld && m_mode != 1) begin
      if (ok) begin
        m_secs = dec(lm) * 60 + dec(ls);
        m_mode = 0;
      end else begin
        m_err = 1;
      end
    end else if (m_mode == 1) begin
      if (tk && m_secs > 0) m_secs = m_secs - 1;
      if (tk && m_secs == 0) begin
        m_mode = 3;
        m_done = 1;
      end else if (ps) begin
        m_mode = 2;
      end
    end else if (st && (m_mode == 0 || m_mode == 2) &&
                 m_secs > 0) begin
      m_mode = 1;
    end
  endtask

  task automatic step(input bit r, tk, ld,
                      input logic [7:0] lm, ls,
                      input bit st, ps);
    rst      = r;
    tick     = tk;
    load     = ld;
    load_min = lm;
    load_sec = ls;
    start    = st;
    pause    = ps;
    model(r, tk, ld, lm, ls, st, ps);
    @(posedge clk);
    #1;
    chk("min", min, bcd(m_secs / 60));
    chk("sec", sec, bcd(m_secs % 60));
    chk("running", {7'd0, running}, {7'd0, m_mode == 1});
    chk("done", {7'd0, done}, {7'd0, m_done});
    chk("err", {7'd0, err}, {7'd0, m_err});
  endtask

  task automatic nop();
    step(0, 0, 0, 8'h00, 8'h00, 0, 0);
  endtask

  task automatic ld(input logic [7:0] lm, ls);
    step(0, 0, 1, lm, ls, 0, 0);
  endtask

  task automatic go();
    step(0, 0, 0, 8'h00, 8'h00, 1, 0);
  endtask

  task automatic tk(input int n);
    for (int i = 0; i < n; i++)
      step(0, 1, 0, 8'h00, 8'h00, 0, 0);
  endtask

  initial begin
    logic [7:0] lm;
    logic [7:0] ls;
    int r;

    step(1, 0, 0, 8'h00, 8'h00, 0, 0);
    chk("rst_min", min, 8'h00);
    chk("rst_run", {7'd0, running}, 8'h00);

    // 01:00 full run to expiry
    ld(8'h01, 8'h00);
    go();
    tk(1);
    chk("t1_sec", sec, 8'h59);
    chk("t1_run", {7'd0, running}, 8'h01);
    tk(59);
    chk("exp_sec", sec, 8'h00);
    chk("exp_done", {7'd0, done}, 8'h01);
    nop();
    chk("exp_done2", {7'd0, done}, 8'h00);
    tk(2);
    chk("exp_hold", sec, 8'h00);

    // load ignored while running
    ld(8'h10, 8'h00);
    go();
    tk(1);
    chk("t2_min", min, 8'h09);
    ld(8'h00, 8'h30);
    chk("t2_sec", sec, 8'h59);
    chk("t2_err", {7'd0, err}, 8'h00);

    // pause / resume
    step(0, 0, 0, 8'h00, 8'h00, 0, 1);
    ld(8'h00, 8'h05);
    go();
    tk(2);
    step(0, 0, 0, 8'h00, 8'h00, 0, 1);
    chk("p_run", {7'd0, running}, 8'h00);
    tk(3);
    chk("p_hold", sec, 8'h03);
    go();
    tk(3);
    chk("p_done", {7'd0, done}, 8'h01);

    // rejected loads, start at zero
    step(1, 0, 0, 8'h00, 8'h00, 0, 0);
    ld(8'h00, 8'h60);
    chk("bad_sec", {7'd0, err}, 8'h01);
    ld(8'h9A, 8'h00);
    chk("bad_min", {7'd0, err}, 8'h01);
    go();
    chk("z_start", {7'd0, running}, 8'h00);

    // tick + pause + start together
    ld(8'h00, 8'h10);
    go();
    step(0, 1, 0, 8'h00, 8'h00, 1, 1);
    chk("tps_sec", sec, 8'h09);
    chk("tps_run", {7'd0, running}, 8'h00);

    // max count and reset mid-run
    ld(8'h99, 8'h59);
    go();
    tk(1);
    chk("max_sec", sec, 8'h58);
    ld(8'h05, 8'h17);
    step(0, 0, 0, 8'h00, 8'h00, 0, 1);
    ld(8'h05, 8'h17);
    go();
    step(1, 1, 0, 8'h00, 8'h00, 0, 0);
    chk("rst_mid", min, 8'h00);

    // reset coincident with a done cycle
    ld(8'h00, 8'h01);
    go();
    tk(1);
    step(1, 1, 0, 8'h00, 8'h00, 1, 0);
    chk("rst_done", {7'd0, done}, 8'h00);

    for (int i = 0; i < 4000; i++) begin
      r = int'($urandom_range(0, 99));
      if ($urandom_range(0, 3) == 0) begin
        lm = bcd(int'($urandom_range(0, 99)));
        ls = bcd(int'($urandom_range(0, 59)));
      end else begin
        lm = 8'h00;
        ls = bcd(int'($urandom_range(0, 20)));
      end
      if ($urandom_range(0, 9) == 0) lm = 8'($urandom);
      if ($urandom_range(0, 9) == 0) ls = 8'($urandom);
      step(r == 0,
           $urandom_range(0, 1) == 1,
           $urandom_range(0, 19) == 0,
           lm, ls,
           $urandom_range(0, 5) == 0,
           $urandom_range(0, 15) == 0);
    end

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
